// File: rtl/dmem_dma_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_dma_arbiter_if : core, DMA and data-memory bus bundle           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dmem_dma_arbiter_if #(
    parameter int LEN_W = 8
);
    logic             core_mem_read;
    logic             core_mem_write;
    logic [31:0]      core_addr;
    logic [31:0]      core_wdata;
    logic [2:0]       core_func3;
    logic [31:0]      core_rdata;
    logic             core_stall;

    logic             dma_start;
    logic             dma_we;
    logic [31:0]      dma_addr;
    logic [LEN_W-1:0] dma_len;
    logic [31:0]      dma_wdata;
    logic             dma_beat;
    logic             dma_rvalid;
    logic [31:0]      dma_rdata;
    logic             dma_busy;
    logic             dma_done;

    logic             mem_read;
    logic             mem_write;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [2:0]       mem_func3;
    logic [31:0]      mem_rdata;

    modport slave (
        input  core_mem_read, core_mem_write, core_addr, core_wdata, core_func3,
        output core_rdata, core_stall,
        input  dma_start, dma_we, dma_addr, dma_len, dma_wdata,
        output dma_beat, dma_rvalid, dma_rdata, dma_busy, dma_done,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_func3,
        input  mem_rdata
    );

    modport master (
        output core_mem_read, core_mem_write, core_addr, core_wdata, core_func3,
        input  core_rdata, core_stall,
        output dma_start, dma_we, dma_addr, dma_len, dma_wdata,
        input  dma_beat, dma_rvalid, dma_rdata, dma_busy, dma_done,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_func3,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_dma_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_dma_arbiter : core-priority data-memory arbiter with DMA bursts |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dmem_dma_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int LEN_W      = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dmem_dma_arbiter_if.slave  bus
);
    localparam int WAIT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic              we_q;
    logic [31:0]       cur_addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              rvalid_q;
    logic              done_q;
    logic [31:0]       rdata_q;

    logic              core_acc_w;
    logic              dma_slot_w;

    always_comb begin
        core_acc_w = bus.core_mem_read | bus.core_mem_write;
        dma_slot_w = (state_q == S_BURST) && (!core_acc_w || (wait_cnt_q == WAIT_MAX));

        bus.mem_read   = bus.core_mem_read;
        bus.mem_write  = bus.core_mem_write;
        bus.mem_addr   = bus.core_addr;
        bus.mem_wdata  = bus.core_wdata;
        bus.mem_func3  = bus.core_func3;
        bus.dma_beat   = 1'b0;
        bus.core_stall = 1'b0;

        if (dma_slot_w) begin
            bus.mem_read   = !we_q;
            bus.mem_write  = we_q;
            bus.mem_addr   = cur_addr_q;
            bus.mem_wdata  = bus.dma_wdata;
            bus.mem_func3  = 3'b010;
            bus.dma_beat   = 1'b1;
            bus.core_stall = core_acc_w;
        end
    end

    assign bus.core_rdata = bus.mem_rdata;
    assign bus.dma_busy   = (state_q != S_IDLE);
    assign bus.dma_rvalid = rvalid_q;
    assign bus.dma_rdata  = rdata_q;
    assign bus.dma_done   = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            cur_addr_q  <= 32'd0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.dma_start) begin
                        we_q        <= bus.dma_we;
                        cur_addr_q  <= bus.dma_addr & ~32'h3;
                        remaining_q <= bus.dma_len;
                        wait_cnt_q  <= '0;
                        // A zero-length burst still reports completion, without touching memory
                        if (bus.dma_len != '0) begin
                            state_q <= S_BURST;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (dma_slot_w) begin
                        cur_addr_q  <= cur_addr_q + 32'd4;
                        remaining_q <= remaining_q - LEN_W'(1);
                        wait_cnt_q  <= '0;
                        if (!we_q) begin
                            rdata_q  <= bus.mem_rdata;
                            rvalid_q <= 1'b1;
                        end
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (core_acc_w && (wait_cnt_q != WAIT_MAX)) begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_dma_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_dma_arbiter : scoreboard bench, STARVE_LIM 4 and 0 instances |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dmem_dma_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_dma_arbiter_if #(.LEN_W(8)) bus4 ();
    dmem_dma_arbiter_if #(.LEN_W(8)) bus0 ();

    dmem_dma_arbiter #(.STARVE_LIM(4), .LEN_W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    dmem_dma_arbiter #(.STARVE_LIM(0), .LEN_W(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    // Word-wide data memories: combinational read, write on rising edge
    logic [31:0] mem4 [0:255];
    logic [31:0] mem0 [0:255];
    assign bus4.mem_rdata = mem4[bus4.mem_addr[9:2]];
    assign bus0.mem_rdata = mem0[bus0.mem_addr[9:2]];
    always @(posedge clk) if (bus4.mem_write) mem4[bus4.mem_addr[9:2]] <= bus4.mem_wdata;
    always @(posedge clk) if (bus0.mem_write) mem0[bus0.mem_addr[9:2]] <= bus0.mem_wdata;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus4.core_mem_read = 0; bus4.core_mem_write = 0; bus4.core_addr = 0;
        bus4.core_wdata = 0; bus4.core_func3 = 3'b010;
        bus4.dma_start = 0; bus4.dma_we = 0; bus4.dma_addr = 0; bus4.dma_len = 0; bus4.dma_wdata = 0;
        bus0.core_mem_read = 0; bus0.core_mem_write = 0; bus0.core_addr = 0;
        bus0.core_wdata = 0; bus0.core_func3 = 3'b010;
        bus0.dma_start = 0; bus0.dma_we = 0; bus0.dma_addr = 0; bus0.dma_len = 0; bus0.dma_wdata = 0;
    endtask

    task automatic store4(input logic [31:0] a, input logic [31:0] d);
        next_cycle();
        bus4.core_mem_write = 1; bus4.core_addr = a; bus4.core_wdata = d; bus4.core_func3 = 3'b010;
        next_cycle();
        bus4.core_mem_write = 0;
    endtask

    // Leaves the bench inside cycle 1 (the first cycle after the accepting edge)
    task automatic start4(input logic we, input logic [31:0] a, input logic [7:0] len);
        next_cycle();
        bus4.dma_start = 1; bus4.dma_we = we; bus4.dma_addr = a; bus4.dma_len = len;
        next_cycle();
        bus4.dma_start = 0;
    endtask

    task automatic test_reset();
        int nbeat, ndone, nacc;
        repeat (2) @(posedge clk);
        bus4.core_mem_read = 1; bus4.core_addr = 32'h44;
        @(negedge clk);
        n_cmp++; if (bus4.dma_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", bus4.dma_busy); end
        n_cmp++; if (bus4.dma_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", bus4.dma_done); end
        n_cmp++; if (bus4.dma_rvalid !== 1'b0 || bus4.dma_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %b/%h expected 0/0", bus4.dma_rvalid, bus4.dma_rdata); end
        n_cmp++; if (bus4.mem_read !== 1'b1 || bus4.mem_addr !== 32'h44 || bus4.core_stall !== 1'b0) begin n_bad++; $display("FAIL rst_passthru: got rd=%b addr=%h stall=%b expected 1/00000044/0", bus4.mem_read, bus4.mem_addr, bus4.core_stall); end
        bus4.core_mem_read = 0;
        next_cycle();
        rst_n = 1;

        for (int i = 0; i < 8; i++) store4(32'h300 + 4 * i, 32'h3000 + i);
        start4(1'b0, 32'h300, 8'd8);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) next_cycle();
            @(negedge clk);
            n_cmp++; if (bus4.dma_beat !== 1'b1) begin n_bad++; $display("FAIL abort_pre_beat: cycle %0d got %b expected 1", k, bus4.dma_beat); end
        end
        next_cycle();
        n_cmp++; if (bus4.dma_rvalid !== 1'b1 || bus4.dma_rdata !== 32'h3002) begin n_bad++; $display("FAIL abort_pre_rdata: got %b/%h expected 1/00003002", bus4.dma_rvalid, bus4.dma_rdata); end
        #1 rst_n = 0;
        #1;
        n_cmp++; if (bus4.dma_rvalid !== 1'b0 || bus4.dma_rdata !== 32'h0) begin n_bad++; $display("FAIL abort_async_rdata: got %b/%h expected 0/0", bus4.dma_rvalid, bus4.dma_rdata); end
        n_cmp++; if (bus4.dma_busy !== 1'b0 || bus4.dma_beat !== 1'b0 || bus4.dma_done !== 1'b0) begin n_bad++; $display("FAIL abort_async_state: got busy=%b beat=%b done=%b expected 0/0/0", bus4.dma_busy, bus4.dma_beat, bus4.dma_done); end
        next_cycle();
        next_cycle();
        rst_n = 1;
        nbeat = 0; ndone = 0; nacc = 0;
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            @(negedge clk);
            if (bus4.dma_beat) nbeat++;
            if (bus4.dma_done) ndone++;
            if (bus4.mem_read || bus4.mem_write || bus4.dma_busy) nacc++;
        end
        n_cmp++; if (nbeat !== 0) begin n_bad++; $display("FAIL abort_no_beats: got %0d expected 0", nbeat); end
        n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
        n_cmp++; if (nacc !== 0) begin n_bad++; $display("FAIL abort_no_access: got %0d expected 0", nacc); end
    endtask

    task automatic test_uncontended_write();
        logic [31:0] exp_a[$];
        logic [31:0] exp_v[$];
        logic [31:0] e;
        int nb, done_cyc;
        for (int i = 0; i < 4; i++) exp_a.push_back(32'h100 + 4 * i);
        nb = 0; done_cyc = -1;
        bus4.dma_wdata = 32'hA0;
        start4(1'b1, 32'h103, 8'd4);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) next_cycle();
            bus4.dma_wdata = 32'hA0 + nb;
            @(negedge clk);
            if (bus4.dma_beat) begin
                n_cmp++;
                if (exp_a.size() == 0) begin n_bad++; $display("FAIL uw_extra_beat: cycle %0d addr %h expected none", k, bus4.mem_addr); end
                else begin
                    e = exp_a.pop_front();
                    if (bus4.mem_addr !== e || k !== nb + 1 || bus4.mem_write !== 1'b1 || bus4.mem_wdata !== 32'hA0 + nb) begin
                        n_bad++; $display("FAIL uw_beat: cycle %0d addr %h we %b data %h expected cycle %0d addr %h we 1 data %h", k, bus4.mem_addr, bus4.mem_write, bus4.mem_wdata, nb + 1, e, 32'hA0 + nb);
                    end
                end
                nb++;
            end
            if (bus4.dma_done) done_cyc = k;
        end
        n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL uw_beat_count: got %0d expected 4", nb); end
        n_cmp++; if (done_cyc !== 5) begin n_bad++; $display("FAIL uw_done_cycle: got %0d expected 5", done_cyc); end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus4.core_mem_read = 1; bus4.core_addr = 32'h100 + 4 * i;
            exp_v.push_back(32'hA0 + i);
            @(negedge clk);
            e = exp_v.pop_front();
            n_cmp++; if (bus4.core_rdata !== e) begin n_bad++; $display("FAIL uw_readback: addr %h got %h expected %h", bus4.core_addr, bus4.core_rdata, e); end
        end
        bus4.core_mem_read = 0;
    endtask

    task automatic test_starvation();
        int beat_cyc[$];
        int rv_cyc[$];
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        int c, done_cyc, stall_err;
        logic [31:0] e;
        for (int i = 0; i < 3; i++) store4(32'h380 + 4 * i, 32'h5500 + i);
        for (int j = 1; j <= 3; j++) begin
            beat_cyc.push_back(5 * j);
            rv_cyc.push_back(5 * j + 1);
            exp_a.push_back(32'h380 + 4 * (j - 1));
            exp_d.push_back(32'h5500 + j - 1);
        end
        done_cyc = -1; stall_err = 0;
        start4(1'b0, 32'h380, 8'd3);
        bus4.core_mem_read = 1; bus4.core_addr = 32'h40;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) next_cycle();
            @(negedge clk);
            if (bus4.core_stall !== bus4.dma_beat) stall_err++;
            if (bus4.dma_beat) begin
                n_cmp++;
                if (beat_cyc.size() == 0) begin n_bad++; $display("FAIL sv_extra_beat: cycle %0d", k); end
                else begin
                    c = beat_cyc.pop_front(); e = exp_a.pop_front();
                    if (k !== c || bus4.mem_addr !== e || bus4.mem_read !== 1'b1) begin
                        n_bad++; $display("FAIL sv_beat: cycle %0d addr %h rd %b expected cycle %0d addr %h rd 1", k, bus4.mem_addr, bus4.mem_read, c, e);
                    end
                end
            end
            if (bus4.dma_rvalid) begin
                n_cmp++;
                if (rv_cyc.size() == 0) begin n_bad++; $display("FAIL sv_extra_rvalid: cycle %0d", k); end
                else begin
                    c = rv_cyc.pop_front(); e = exp_d.pop_front();
                    if (k !== c || bus4.dma_rdata !== e) begin
                        n_bad++; $display("FAIL sv_rdata: cycle %0d data %h expected cycle %0d data %h", k, bus4.dma_rdata, c, e);
                    end
                end
            end
            if (bus4.dma_done) done_cyc = k;
        end
        bus4.core_mem_read = 0;
        n_cmp++; if (stall_err !== 0) begin n_bad++; $display("FAIL sv_stall_eq_beat: got %0d bad cycles expected 0", stall_err); end
        n_cmp++; if (beat_cyc.size() !== 0 || rv_cyc.size() !== 0) begin n_bad++; $display("FAIL sv_missing: got %0d beats/%0d rvalids outstanding expected 0/0", beat_cyc.size(), rv_cyc.size()); end
        n_cmp++; if (done_cyc !== 16) begin n_bad++; $display("FAIL sv_done_cycle: got %0d expected 16", done_cyc); end
    endtask

    task automatic test_contended();
        logic [31:0] exp_d[$];
        logic [31:0] e;
        next_cycle();
        bus0.core_mem_write = 1; bus0.core_addr = 32'h200; bus0.core_wdata = 32'h1111_0000;
        next_cycle();
        bus0.core_mem_write = 0;
        next_cycle();
        bus0.dma_start = 1; bus0.dma_we = 0; bus0.dma_addr = 32'h200; bus0.dma_len = 8'd1;
        exp_d.push_back(32'h1111_0000);
        next_cycle();
        bus0.dma_start = 0;
        bus0.core_mem_write = 1; bus0.core_addr = 32'h200; bus0.core_wdata = 32'h2222_0000;
        @(negedge clk);
        n_cmp++; if (bus0.dma_beat !== 1'b1 || bus0.core_stall !== 1'b1) begin n_bad++; $display("FAIL ct_dma_wins: got beat=%b stall=%b expected 1/1", bus0.dma_beat, bus0.core_stall); end
        n_cmp++; if (bus0.mem_read !== 1'b1 || bus0.mem_write !== 1'b0 || bus0.mem_addr !== 32'h200) begin n_bad++; $display("FAIL ct_mem_bus: got rd=%b wr=%b addr=%h expected 1/0/00000200", bus0.mem_read, bus0.mem_write, bus0.mem_addr); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (bus0.core_stall !== 1'b0 || bus0.mem_write !== 1'b1 || bus0.dma_done !== 1'b1) begin n_bad++; $display("FAIL ct_store_next: got stall=%b wr=%b done=%b expected 0/1/1", bus0.core_stall, bus0.mem_write, bus0.dma_done); end
        e = exp_d.pop_front();
        n_cmp++; if (bus0.dma_rvalid !== 1'b1 || bus0.dma_rdata !== e) begin n_bad++; $display("FAIL ct_old_data: got %b/%h expected 1/%h", bus0.dma_rvalid, bus0.dma_rdata, e); end
        next_cycle();
        bus0.core_mem_write = 0; bus0.core_mem_read = 1;
        @(negedge clk);
        n_cmp++; if (bus0.core_rdata !== 32'h2222_0000) begin n_bad++; $display("FAIL ct_store_landed: got %h expected 22220000", bus0.core_rdata); end
        bus0.core_mem_read = 0;
    endtask

    task automatic test_edge_cases();
        logic [31:0] exp_a[$];
        logic [31:0] e;
        int done_cyc, nb;
        // zero length
        start4(1'b0, 32'h100, 8'd0);
        @(negedge clk);
        n_cmp++; if (bus4.dma_done !== 1'b1 || bus4.dma_busy !== 1'b1) begin n_bad++; $display("FAIL len0_done: got done=%b busy=%b expected 1/1", bus4.dma_done, bus4.dma_busy); end
        n_cmp++; if (bus4.mem_read !== 1'b0 || bus4.mem_write !== 1'b0 || bus4.dma_beat !== 1'b0) begin n_bad++; $display("FAIL len0_no_access: got rd=%b wr=%b beat=%b expected 0/0/0", bus4.mem_read, bus4.mem_write, bus4.dma_beat); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (bus4.dma_done !== 1'b0 || bus4.dma_busy !== 1'b0) begin n_bad++; $display("FAIL len0_idle: got done=%b busy=%b expected 0/0", bus4.dma_done, bus4.dma_busy); end

        // start during burst is ignored
        exp_a.push_back(32'h140); exp_a.push_back(32'h144);
        nb = 0; done_cyc = -1;
        bus4.dma_wdata = 32'h77;
        start4(1'b1, 32'h140, 8'd2);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) next_cycle();
            if (k == 1) begin bus4.dma_start = 1; bus4.dma_we = 0; bus4.dma_addr = 32'h1C0; bus4.dma_len = 8'd5; end
            if (k == 2) bus4.dma_start = 0;
            @(negedge clk);
            if (bus4.dma_beat) begin
                n_cmp++;
                e = (exp_a.size() != 0) ? exp_a.pop_front() : 32'hDEAD_BEEF;
                if (bus4.mem_addr !== e || bus4.mem_write !== 1'b1) begin n_bad++; $display("FAIL busy_start_beat: cycle %0d addr %h wr %b expected addr %h wr 1", k, bus4.mem_addr, bus4.mem_write, e); end
                nb++;
            end
            if (bus4.dma_done) done_cyc = k;
        end
        n_cmp++; if (nb !== 2 || done_cyc !== 3) begin n_bad++; $display("FAIL busy_start_ignored: got %0d beats done@%0d expected 2 beats done@3", nb, done_cyc); end

        // address wrap
        exp_a.delete();
        exp_a.push_back(32'hFFFF_FFFC); exp_a.push_back(32'h0000_0000);
        nb = 0; done_cyc = -1;
        bus4.dma_wdata = 32'hC0;
        start4(1'b1, 32'hFFFF_FFFC, 8'd2);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) next_cycle();
            @(negedge clk);
            if (bus4.dma_beat) begin
                n_cmp++;
                e = (exp_a.size() != 0) ? exp_a.pop_front() : 32'hDEAD_BEEF;
                if (bus4.mem_addr !== e) begin n_bad++; $display("FAIL wrap_beat: cycle %0d addr %h expected %h", k, bus4.mem_addr, e); end
                nb++;
            end
            if (bus4.dma_done) done_cyc = k;
        end
        n_cmp++; if (nb !== 2 || done_cyc !== 3) begin n_bad++; $display("FAIL wrap_count: got %0d beats done@%0d expected 2 beats done@3", nb, done_cyc); end
    endtask

    task automatic test_back_to_back();
        int beat_cyc[$];
        int done_q[$];
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        int c, nb;
        logic [31:0] e;
        beat_cyc = '{1, 2, 5, 6};
        done_q   = '{3, 7};
        exp_a    = '{32'h180, 32'h184, 32'h180, 32'h184};
        exp_d    = '{32'hB0, 32'hB1};
        nb = 0;
        bus4.dma_wdata = 32'hB0;
        start4(1'b1, 32'h180, 8'd2);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) next_cycle();
            bus4.dma_wdata = 32'hB0 + nb;
            if (k == 4) begin bus4.dma_start = 1; bus4.dma_we = 0; bus4.dma_addr = 32'h180; bus4.dma_len = 8'd2; end
            if (k == 5) bus4.dma_start = 0;
            @(negedge clk);
            if (k == 4) begin
                n_cmp++; if (bus4.dma_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: cycle 4 busy got %b expected 0", bus4.dma_busy); end
            end
            if (bus4.dma_beat) begin
                n_cmp++;
                if (beat_cyc.size() == 0) begin n_bad++; $display("FAIL b2b_extra_beat: cycle %0d", k); end
                else begin
                    c = beat_cyc.pop_front(); e = exp_a.pop_front();
                    if (k !== c || bus4.mem_addr !== e) begin n_bad++; $display("FAIL b2b_beat: cycle %0d addr %h expected cycle %0d addr %h", k, bus4.mem_addr, c, e); end
                end
                nb++;
            end
            if (bus4.dma_rvalid) begin
                n_cmp++;
                e = (exp_d.size() != 0) ? exp_d.pop_front() : 32'hDEAD_BEEF;
                if (bus4.dma_rdata !== e) begin n_bad++; $display("FAIL b2b_rdata: cycle %0d got %h expected %h", k, bus4.dma_rdata, e); end
            end
            if (bus4.dma_done) begin
                n_cmp++;
                c = (done_q.size() != 0) ? done_q.pop_front() : -1;
                if (k !== c) begin n_bad++; $display("FAIL b2b_done: cycle %0d expected cycle %0d", k, c); end
            end
        end
        n_cmp++; if (beat_cyc.size() !== 0 || exp_d.size() !== 0 || done_q.size() !== 0) begin n_bad++; $display("FAIL b2b_outstanding: got %0d/%0d/%0d expected 0/0/0", beat_cyc.size(), exp_d.size(), done_q.size()); end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_uncontended_write();
        test_starvation();
        test_contended();
        test_edge_cases();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
